// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES registered
// segments with valid/ready flow control, sustaining one operation per cycle.
module pipelined_add_sub #(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int unsigned W = N / STAGES;

  // Stage registers: r_*[k] holds the state leaving stage k.
  logic         r_vld [STAGES];
  logic         r_c   [STAGES];
  logic [N-1:0] r_a   [STAGES];
  logic [N-1:0] r_b   [STAGES];
  logic [N-1:0] r_s   [STAGES];

  logic         w_vld [STAGES];
  logic         w_ci  [STAGES];
  logic [N-1:0] w_a   [STAGES];
  logic [N-1:0] w_b   [STAGES];
  logic [N-1:0] w_s   [STAGES];
  logic [N-1:0] w_so  [STAGES];
  logic [W:0]   w_seg [STAGES];
  logic         w_adv;

  // Operands ride along whole; each stage reads only its own slice, and the
  // last stage keeps the sign bits needed for overflow.
  always_comb begin
    w_vld[0] = in_valid;
    w_ci[0]  = sub | cin;
    w_a[0]   = a;
    w_b[0]   = sub ? ~b : b;
    w_s[0]   = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_vld[k] = r_vld[k-1];
      w_ci[k]  = r_c[k-1];
      w_a[k]   = r_a[k-1];
      w_b[k]   = r_b[k-1];
      w_s[k]   = r_s[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_seg[k] = {1'b0, w_a[k][k*W +: W]} + {1'b0, w_b[k][k*W +: W]}
               + {{W{1'b0}}, w_ci[k]};
      w_so[k]  = w_s[k];
      w_so[k][k*W +: W] = w_seg[k][W-1:0];
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
      end
    end else if (w_adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld[k];
        r_c[k]   <= w_seg[k][W];
        r_a[k]   <= w_a[k];
        r_b[k]   <= w_b[k];
        r_s[k]   <= w_so[k];
      end
    end
  end

  assign sum  = r_s[STAGES-1];
  assign cout = r_c[STAGES-1];
  assign ovf  = (r_a[STAGES-1][N-1] == r_b[STAGES-1][N-1]) &&
                (r_s[STAGES-1][N-1] != r_a[STAGES-1][N-1]);

endmodule
